// File: rtl/cpu_pkg.sv
// Shared LEGv8 CPU definitions: datapath widths and the fetch-stage state encoding.
package cpu_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 64;

    localparam logic [PC_W-1:0] PC_INC = 64'd4;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_out_buffer.sv
// Fetch-to-decode pipeline register with a one-entry skid, so a response that
// arrives while decode is stalled is parked instead of lost.
module fetch_out_buffer
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [INST_W-1:0] in_inst,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_free,
    output logic              out_valid,
    output logic [INST_W-1:0] out_inst,
    output logic [PC_W-1:0]   out_pc,
    input  logic              out_ready
);

    logic              out_valid_q, out_valid_d;
    logic [INST_W-1:0] out_inst_q, out_inst_d;
    logic [PC_W-1:0]   out_pc_q, out_pc_d;
    logic              skid_valid_q, skid_valid_d;
    logic [INST_W-1:0] skid_inst_q, skid_inst_d;
    logic [PC_W-1:0]   skid_pc_q, skid_pc_d;

    assign out_free  = !out_valid_q || out_ready;
    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign out_pc    = out_pc_q;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_inst_d   = out_inst_q;
        out_pc_d     = out_pc_q;
        skid_valid_d = skid_valid_q;
        skid_inst_d  = skid_inst_q;
        skid_pc_d    = skid_pc_q;

        if (flush) begin
            // Payload registers keep their contents; only the valids are dropped.
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (out_ready) begin
                out_valid_d  = 1'b1;
                out_inst_d   = skid_inst_q;
                out_pc_d     = skid_pc_q;
                skid_valid_d = 1'b0;
            end
        end else if (in_valid) begin
            if (out_free) begin
                out_valid_d = 1'b1;
                out_inst_d  = in_inst;
                out_pc_d    = in_pc;
            end else begin
                skid_valid_d = 1'b1;
                skid_inst_d  = in_inst;
                skid_pc_d    = in_pc;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_inst_q   <= '0;
            out_pc_q     <= '0;
            skid_valid_q <= 1'b0;
            skid_inst_q  <= '0;
            skid_pc_q    <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_inst_q   <= out_inst_d;
            out_pc_q     <= out_pc_d;
            skid_valid_q <= skid_valid_d;
            skid_inst_q  <= skid_inst_d;
            skid_pc_q    <= skid_pc_d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// LEGv8 fetch stage: PC, instruction-memory req/ready sequencing and branch
// redirect; instructions are handed to decode through fetch_out_buffer.
//
// state | meaning
// REQ   | request outstanding at IMemAddr = PC
// HOLD  | no request; newest response parked in skid until decode drains it
// DRAIN | redirected while a request was in flight; old address held, response dropped
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 64'h0
) (
    input  logic              CLK,
    input  logic              Reset_L,
    output logic [PC_W-1:0]   IMemAddr,
    output logic              IMemReq,
    input  logic              IMemRdy,
    input  logic [INST_W-1:0] IMemData,
    input  logic              BranchTaken,
    input  logic [PC_W-1:0]   BranchPC,
    input  logic [PC_W-1:0]   BusImm,
    output logic [INST_W-1:0] InstOut,
    output logic [PC_W-1:0]   PCOut,
    output logic              InstValid,
    input  logic              DecodeReady
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] drain_addr_q, drain_addr_d;
    logic [PC_W-1:0] imm_off;
    logic [PC_W-1:0] target_pc;
    logic            load;
    logic            out_free;

    // BusImm counts words; the shift drops its top two bits (mod 2^64 add).
    assign imm_off   = BusImm << 2;
    assign target_pc = word_align(BranchPC + imm_off);

    assign IMemReq  = Reset_L && (state_q != HOLD);
    assign IMemAddr = (state_q == DRAIN) ? drain_addr_q : pc_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        load         = 1'b0;

        if (BranchTaken) begin
            pc_d = target_pc;
            unique case (state_q)
                REQ: begin
                    if (!IMemRdy) begin
                        state_d      = DRAIN;
                        drain_addr_d = pc_q;
                    end
                end
                HOLD:    state_d = REQ;
                DRAIN:   state_d = IMemRdy ? REQ : DRAIN;
                default: state_d = REQ;
            endcase
        end else begin
            unique case (state_q)
                REQ: begin
                    if (IMemRdy) begin
                        load = 1'b1;
                        pc_d = pc_q + PC_INC;
                        if (!out_free) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (DecodeReady) begin
                        state_d = REQ;
                    end
                end
                DRAIN: begin
                    if (IMemRdy) begin
                        state_d = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state_q      <= REQ;
            pc_q         <= word_align(RESET_PC);
            drain_addr_q <= word_align(RESET_PC);
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    fetch_out_buffer u_out_buf (
        .clk       (CLK),
        .rst_n     (Reset_L),
        .flush     (BranchTaken),
        .in_valid  (load),
        .in_inst   (IMemData),
        .in_pc     (pc_q),
        .out_free  (out_free),
        .out_valid (InstValid),
        .out_inst  (InstOut),
        .out_pc    (PCOut),
        .out_ready (DecodeReady)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a per-cycle vector table followed by
// hand-written asynchronous-reset-in-HOLD and restart sequences.
module tb_instruction_fetch;

    localparam logic [63:0] RST_PC = 64'h100;

    localparam logic [31:0] D0 = 32'hA000_0000;
    localparam logic [31:0] D1 = 32'hA000_0001;
    localparam logic [31:0] D2 = 32'hA000_0002;
    localparam logic [31:0] D3 = 32'hA000_0003;
    localparam logic [31:0] D4 = 32'hA000_0004;
    localparam logic [31:0] D5 = 32'hA000_0005;
    localparam logic [31:0] D6 = 32'hA000_0006;
    localparam logic [31:0] D7 = 32'hA000_0007;
    localparam logic [31:0] DX = 32'hDEAD_0001;
    localparam logic [31:0] DY = 32'hDEAD_0002;
    localparam logic [31:0] DR = 32'hB000_0000;

    logic        CLK = 1'b0;
    logic        Reset_L = 1'b0;
    logic [63:0] IMemAddr;
    logic        IMemReq;
    logic        IMemRdy = 1'b0;
    logic [31:0] IMemData = '0;
    logic        BranchTaken = 1'b0;
    logic [63:0] BranchPC = '0;
    logic [63:0] BusImm = '0;
    logic [31:0] InstOut;
    logic [63:0] PCOut;
    logic        InstValid;
    logic        DecodeReady = 1'b0;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    instruction_fetch #(.RESET_PC(RST_PC)) dut (
        .CLK         (CLK),
        .Reset_L     (Reset_L),
        .IMemAddr    (IMemAddr),
        .IMemReq     (IMemReq),
        .IMemRdy     (IMemRdy),
        .IMemData    (IMemData),
        .BranchTaken (BranchTaken),
        .BranchPC    (BranchPC),
        .BusImm      (BusImm),
        .InstOut     (InstOut),
        .PCOut       (PCOut),
        .InstValid   (InstValid),
        .DecodeReady (DecodeReady)
    );

    typedef struct {
        logic        rdy;
        logic [31:0] data;
        logic        dr;
        logic        bt;
        logic [63:0] bpc;
        logic [63:0] imm;
        logic        e_req;
        logic [63:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [63:0] e_pco;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input logic rdy, input logic [31:0] data, input logic dr,
                        input logic bt, input logic [63:0] bpc, input logic [63:0] imm,
                        input logic e_req, input logic [63:0] e_addr, input logic e_iv,
                        input logic [31:0] e_inst, input logic [63:0] e_pco);
        vec_t v;
        v.rdy = rdy; v.data = data; v.dr = dr; v.bt = bt; v.bpc = bpc; v.imm = imm;
        v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_inst = e_inst; v.e_pco = e_pco;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        // rdy data dr bt bpc imm | req addr iv inst pco
        addv(1, D0, 1, 0, 0, 0,              1, 64'h100, 0, 0,  0);        // c0
        addv(1, D1, 1, 0, 0, 0,              1, 64'h104, 1, D0, 64'h100);  // c1
        addv(1, D2, 1, 0, 0, 0,              1, 64'h108, 1, D1, 64'h104);  // c2
        addv(1, D3, 0, 0, 0, 0,              1, 64'h10C, 1, D2, 64'h108);  // c3 D3 -> skid
        addv(0, 0,  0, 0, 0, 0,              0, 64'h110, 1, D2, 64'h108);  // c4 HOLD
        addv(0, 0,  0, 0, 0, 0,              0, 64'h110, 1, D2, 64'h108);  // c5
        addv(0, 0,  1, 0, 0, 0,              0, 64'h110, 1, D2, 64'h108);  // c6 drain skid
        addv(0, 0,  1, 0, 0, 0,              1, 64'h110, 1, D3, 64'h10C);  // c7
        addv(1, D4, 1, 0, 0, 0,              1, 64'h110, 0, 0,  0);        // c8
        addv(1, DX, 0, 1, 64'h200, 64'hFFFF_FFFF_FFFF_FFFE,
                                             1, 64'h114, 1, D4, 64'h110);  // c9 redirect + rdy
        addv(0, 0,  1, 0, 0, 0,              1, 64'h1F8, 0, 0,  0);        // c10
        addv(0, 0,  1, 0, 0, 0,              1, 64'h1F8, 0, 0,  0);        // c11
        addv(0, 0,  1, 1, 64'h300, 64'h4,    1, 64'h1F8, 0, 0,  0);        // c12 redirect, no rdy
        addv(0, 0,  1, 1, 64'h400, 64'h1,    1, 64'h1F8, 0, 0,  0);        // c13 DRAIN, newer target
        addv(1, DY, 1, 0, 0, 0,              1, 64'h1F8, 0, 0,  0);        // c14 dropped response
        addv(0, 0,  1, 0, 0, 0,              1, 64'h404, 0, 0,  0);        // c15
        addv(1, D5, 1, 0, 0, 0,              1, 64'h404, 0, 0,  0);        // c16
        addv(0, 0,  1, 0, 0, 0,              1, 64'h408, 1, D5, 64'h404);  // c17
        addv(1, D6, 0, 0, 0, 0,              1, 64'h408, 0, 0,  0);        // c18
        addv(1, D7, 0, 0, 0, 0,              1, 64'h40C, 1, D6, 64'h408);  // c19 D7 -> skid
        addv(0, 0,  0, 0, 0, 0,              0, 64'h410, 1, D6, 64'h408);  // c20 HOLD

        repeat (2) @(posedge CLK);
        #1;
        chk("rst_req",   {63'b0, IMemReq},   64'h0);
        chk("rst_addr",  IMemAddr,           RST_PC);
        chk("rst_valid", {63'b0, InstValid}, 64'h0);
        chk("rst_inst",  {32'b0, InstOut},   64'h0);
        chk("rst_pcout", PCOut,              64'h0);
        #1 Reset_L = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge CLK);
            IMemRdy     = vq[i].rdy;
            IMemData    = vq[i].data;
            DecodeReady = vq[i].dr;
            BranchTaken = vq[i].bt;
            BranchPC    = vq[i].bpc;
            BusImm      = vq[i].imm;
            #1;
            chk($sformatf("v%0d_req", i),   {63'b0, IMemReq},   {63'b0, vq[i].e_req});
            chk($sformatf("v%0d_addr", i),  IMemAddr,           vq[i].e_addr);
            chk($sformatf("v%0d_valid", i), {63'b0, InstValid}, {63'b0, vq[i].e_iv});
            if (vq[i].e_iv) begin
                chk($sformatf("v%0d_inst", i),  {32'b0, InstOut}, {32'b0, vq[i].e_inst});
                chk($sformatf("v%0d_pcout", i), PCOut,            vq[i].e_pco);
            end
        end

        // Asynchronous reset in the middle of HOLD, between clock edges.
        @(posedge CLK);
        #3 Reset_L = 1'b0;
        #1;
        chk("mid_rst_valid", {63'b0, InstValid}, 64'h0);
        chk("mid_rst_inst",  {32'b0, InstOut},   64'h0);
        chk("mid_rst_pcout", PCOut,              64'h0);
        chk("mid_rst_req",   {63'b0, IMemReq},   64'h0);
        chk("mid_rst_addr",  IMemAddr,           RST_PC);

        @(negedge CLK);
        IMemRdy = 1'b0; DecodeReady = 1'b1; BranchTaken = 1'b0;
        @(posedge CLK);
        #2 Reset_L = 1'b1;

        @(negedge CLK);
        IMemRdy = 1'b1; IMemData = DR; DecodeReady = 1'b1;
        #1;
        chk("restart_req",  {63'b0, IMemReq},   64'h1);
        chk("restart_addr", IMemAddr,           RST_PC);
        chk("restart_iv0",  {63'b0, InstValid}, 64'h0);

        @(negedge CLK);
        IMemRdy = 1'b0;
        #1;
        chk("restart_iv1",   {63'b0, InstValid}, 64'h1);
        chk("restart_inst",  {32'b0, InstOut},   {32'b0, DR});
        chk("restart_pcout", PCOut,              RST_PC);
        chk("restart_addr2", IMemAddr,           RST_PC + 64'd4);

        // The stale skid entry from before reset must not resurface.
        @(negedge CLK);
        #1;
        chk("restart_no_stale", {63'b0, InstValid}, 64'h0);
        chk("restart_req2",     {63'b0, IMemReq},   64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the LEGv8 CPU: holds the PC, requests 32-bit instructions from instruction memory over a req/ready handshake, and presents each instruction with its PC to decode through a valid/ready pipeline register. It consumes the sign-extended immediate (BusImm) and resolved branch outcome from downstream to compute the redirect target PC + (BusImm << 2). Its InstOut[25:0] feeds the sign extender.

## Interface
- RESET_PC, 64'h0, PC loaded at reset; bits [1:0] forced to 0
- CLK  in  1  clock, all state on rising edge
- Reset_L  in  1  asynchronous active-low reset
- IMemAddr  out  64  instruction address, always word aligned
- IMemReq  out  1  fetch request; held with stable IMemAddr until IMemRdy
- IMemRdy  in  1  response valid; IMemData sampled this cycle
- IMemData  in  32  instruction word
- BranchTaken  in  1  one-cycle redirect pulse from branch resolution
- BranchPC  in  64  PC of the resolving branch
- BusImm  in  64  sign-extended branch offset, in words
- InstOut  out  32  instruction to decode
- PCOut  out  64  PC of InstOut
- InstValid  out  1  InstOut/PCOut valid
- DecodeReady  in  1  decode accepts InstOut when InstValid && DecodeReady

## Operation
- States: REQ (IMemReq=1, IMemAddr=PC), HOLD (IMemReq=0, response parked in skid), DRAIN (IMemReq=1 at old address, response discarded).
- Output register free: out_free = !InstValid || DecodeReady.
- REQ, IMemRdy=1, out_free: load InstOut=IMemData, PCOut=PC, InstValid=1; PC <= PC+4; stay REQ.
- REQ, IMemRdy=1, !out_free: capture into skid {data, PC}; PC <= PC+4; go HOLD.
- HOLD, DecodeReady=1: skid moves to output register (InstValid stays 1); skid cleared; go REQ.
- DecodeReady with InstValid and no new load: InstValid <= 0.
- Redirect (BranchTaken=1) has priority over all of the above in the same cycle:
  - PC <= BranchPC + {BusImm[61:0], 2'b00}, modulo 2^64.
  - InstValid <= 0, skid cleared (flush).
  - REQ with IMemRdy=0: go DRAIN (request outstanding, address must stay stable).
  - REQ with IMemRdy=1: response discarded, stay REQ; next IMemAddr = target.
  - HOLD or DRAIN: go REQ (DRAIN+IMemRdy) or stay DRAIN (DRAIN, no IMemRdy); PC takes newest target.
- DRAIN, IMemRdy=1: discard data, go REQ with current PC.
- PC+4 wraps modulo 2^64; no misalignment possible.

## Timing
- Reset (asynchronous, immediate): PC=RESET_PC, state REQ, InstValid=0, InstOut=0, PCOut=0, skid empty. IMemReq=0 while Reset_L=0; IMemReq=1 from first cycle after deassertion.
- Reset mid-request: outstanding request abandoned; memory must tolerate.
- Fetch latency: InstValid rises the cycle after IMemRdy. Zero-wait memory (IMemRdy in the first REQ cycle) gives one instruction per cycle.
- Redirect penalty: target on IMemAddr the cycle after BranchTaken when no request outstanding; otherwise the cycle after the drained IMemRdy.
- InstOut/PCOut stable while InstValid && !DecodeReady.
- IMemAddr changes only on cycles following an IMemRdy or a redirect taken with no outstanding request.

## Structure
- Shared cpu_pkg: fetch state enum {REQ, HOLD, DRAIN}, INST_W=32, PC_W=64, PC_INC=4.
- One sub-module: fetch_out_buffer, holding output register plus one-entry skid with valid/ready in, valid/ready out and flush; FSM, PC and target adder stay in instruction_fetch.

## Test plan
- Reset with RESET_PC=64'h100, IMemRdy=1 every cycle, DecodeReady=1 -> IMemAddr 0x100,0x104,0x108 on consecutive cycles; PCOut follows one cycle later; InstValid continuous.
- DecodeReady=0 for 3 cycles with instruction A held -> B enters skid, IMemReq=0 in HOLD; A then B delivered in order, no loss or duplication.
- BranchTaken with BranchPC=0x200, BusImm=64'hFFFF_FFFF_FFFF_FFFE -> next IMemAddr=0x1F8, InstValid=0 next cycle.
- Redirect while IMemRdy=0 with 2-cycle memory -> IMemAddr held at old PC through DRAIN, that response dropped, then target requested.
- BranchTaken and IMemRdy in same cycle -> returned data never appears on InstOut; next IMemAddr=target.
- Reset_L asserted mid-HOLD -> InstValid, InstOut, PCOut immediately 0; PC=RESET_PC; fetch restarts cleanly.
